cr_rbus_ring_master: RTL

Ring-origin master for the register bus (rbus) ring. It accepts one host register access at a time, launches it as a single-cycle strobe onto the head of the ring, and waits for the addressed node to return ack/err_ack at the ring tail. Each node on the ring is a per-block regfile such as cr_cg. The block terminates the ring and returns read data plus status to the host, with a timeout for unclaimed addresses.

---
 rtl/cr_rbus_ring_master_if.sv | 39 +++
 rtl/cr_rbus_ring_master.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/cr_rbus_ring_master_if.sv
// Host-side request/response handshake plus the rbus ring head/tail bundle
// for the ring-origin master.
interface cr_rbus_ring_master_if #(
  parameter int N_RBUS_ADDR_BITS = 16,
  parameter int N_RBUS_DATA_BITS = 32
);
  typedef struct packed {
    logic [N_RBUS_ADDR_BITS-1:0] addr;
    logic                        wr_strb;
    logic [N_RBUS_DATA_BITS-1:0] wr_data;
    logic                        rd_strb;
    logic [N_RBUS_DATA_BITS-1:0] rd_data;
    logic                        ack;
    logic                        err_ack;
  } rbus_ring_t;

  logic                        req_valid;
  logic                        req_ready;
  logic                        req_wr;
  logic [N_RBUS_ADDR_BITS-1:0] req_addr;
  logic [N_RBUS_DATA_BITS-1:0] req_wdata;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [N_RBUS_DATA_BITS-1:0] rsp_rdata;
  logic [1:0]                  rsp_status;
  logic                        late_ack;
  rbus_ring_t                  rbus_ring_o;
  rbus_ring_t                  rbus_ring_i;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready, rbus_ring_i,
    output req_ready, rsp_valid, rsp_rdata, rsp_status, late_ack, rbus_ring_o
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready, rbus_ring_i,
    input  req_ready, rsp_valid, rsp_rdata, rsp_status, late_ack, rbus_ring_o
  );
endinterface

// File: rtl/cr_rbus_ring_master.sv
// rbus ring origin: launches one host access as a single-cycle strobe at the
// ring head, waits for ack/err_ack at the tail (with timeout), returns status.
module cr_rbus_ring_master #(
  parameter int N_RBUS_ADDR_BITS = 16,
  parameter int N_RBUS_DATA_BITS = 32,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  cr_rbus_ring_master_if.master bus
);
  localparam int AW = N_RBUS_ADDR_BITS;
  localparam int DW = N_RBUS_DATA_BITS;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_ERR     = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic            req_ready_q, req_ready_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            wr_strb_q, wr_strb_d;
  logic            rd_strb_q, rd_strb_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_status_q, rsp_status_d;
  logic            late_ack_q, late_ack_d;
  logic            tail_resp;

  assign tail_resp = bus.rbus_ring_i.ack | bus.rbus_ring_i.err_ack;

  // Returning strobes and address/data at the tail are the unclaimed request.
  logic unused_ring_tail;
  assign unused_ring_tail = ^{bus.rbus_ring_i.addr, bus.rbus_ring_i.wr_strb,
                              bus.rbus_ring_i.wr_data, bus.rbus_ring_i.rd_strb};

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_strb_d    = 1'b0;
    rd_strb_d    = 1'b0;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;
    late_ack_d   = tail_resp && (state_q != S_WAIT);

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          state_d     = S_ISSUE;
          req_ready_d = 1'b0;
          wr_d        = bus.req_wr;
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
          wr_strb_d   = bus.req_wr;
          rd_strb_d   = !bus.req_wr;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // Priority: err_ack over ack over timeout.
        if (bus.rbus_ring_i.err_ack) begin
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_ERR;
          rsp_rdata_d  = '0;
        end else if (bus.rbus_ring_i.ack) begin
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_OK;
          rsp_rdata_d  = wr_q ? '0 : bus.rbus_ring_i.rd_data;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_TIMEOUT;
          rsp_rdata_d  = '0;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d      = S_IDLE;
          req_ready_d  = 1'b1;
          rsp_valid_d  = 1'b0;
          rsp_rdata_d  = '0;
          rsp_status_d = ST_OK;
          wr_d         = 1'b0;
          addr_d       = '0;
          wdata_d      = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_strb_q    <= 1'b0;
      rd_strb_q    <= 1'b0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= '0;
      late_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_strb_q    <= wr_strb_d;
      rd_strb_q    <= rd_strb_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
      late_ack_q   <= late_ack_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.late_ack   = late_ack_q;
  // The master originates the ring, so the returned-response fields start at 0.
  assign bus.rbus_ring_o = {addr_q, wr_strb_q, wdata_q, rd_strb_q, {DW{1'b0}}, 1'b0, 1'b0};
endmodule
